// File: rtl/bit_selection_pkg.sv
// bit_selection_pkg: FSM encoding, command width and beat-count constants for the window sequencer
package bit_selection_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam int COMMAND_WIDTH = 3;
  localparam logic [3:0] COUNT_ZERO_BEATS = 4'd8;
  function automatic logic [3:0] beats(input logic [2:0] c);
    return c == 3'd0 ? COUNT_ZERO_BEATS : {1'b0, c};
  endfunction
endpackage

// File: rtl/bit_selection_seq_ctrl_if.sv
// bit_selection_seq_ctrl_if: upstream word, configuration and downstream beat signals
interface bit_selection_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COMMAND_WIDTH = 3
);
  logic i_valid;
  logic [DATA_WIDTH-1:0] i_data_bus;
  logic o_ready;
  logic i_en;
  logic [COMMAND_WIDTH-1:0] i_cfg_start;
  logic [COMMAND_WIDTH-1:0] i_cfg_stride;
  logic [2:0] i_cfg_count;
  logic o_valid;
  logic [DATA_WIDTH/2-1:0] o_data_bus;
  logic i_ready;
  logic [COMMAND_WIDTH-1:0] o_cmd;
  logic o_last;
  modport slave (
    input i_valid, i_data_bus, i_en, i_cfg_start, i_cfg_stride, i_cfg_count, i_ready,
    output o_ready, o_valid, o_data_bus, o_cmd, o_last
  );
  modport master (
    output i_valid, i_data_bus, i_en, i_cfg_start, i_cfg_stride, i_cfg_count, i_ready,
    input o_ready, o_valid, o_data_bus, o_cmd, o_last
  );
endinterface

// File: rtl/bit_selection_16x8_comb.sv
// bit_selection_16x8_comb: selects word[cmd+1 +: 8], zero when not valid
module bit_selection_16x8_comb (
  input  logic        i_valid,
  input  logic [15:0] i_data,
  input  logic [2:0]  i_cmd,
  output logic [7:0]  o_data
);
  logic [15:0] sh;
  always_comb begin
    sh = i_data >> ({1'b0, i_cmd} + 4'd1);
    o_data = i_valid ? sh[7:0] : 8'd0;
  end
endmodule

// File: rtl/bit_selection_seq_ctrl.sv
// bit_selection_seq_ctrl: strided 8-bit window sequencer over latched 16-bit words; BIT_SELECTION_SEQ_STATS_EN adds a beat counter
module bit_selection_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int COMMAND_WIDTH = bit_selection_pkg::COMMAND_WIDTH
) (
  input  logic clk,
  input  logic rst,
  bit_selection_seq_ctrl_if.slave bus,
  output logic [15:0] o_beat_cnt
);
  import bit_selection_pkg::*;
  logic [0:0] state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [COMMAND_WIDTH-1:0] cmd_q, cmd_d, stride_q, stride_d;
  logic [3:0] rem_q, rem_d;
  logic run, beat, last, acc;
  assign run = state_q == RUN;
  assign beat = run && bus.i_ready;
  assign last = run && rem_q == 4'd1;
  // a last-beat handshake frees the slot in the same cycle so words stream without a bubble
  assign bus.o_ready = bus.i_en && (!run || (beat && last));
  assign acc = bus.i_valid && bus.o_ready;
  assign bus.o_valid = run;
  assign bus.o_cmd = run ? cmd_q : '0;
  assign bus.o_last = last;
  always_comb begin
    state_d = acc ? RUN : (beat && last) ? IDLE : state_q;
    word_d = acc ? bus.i_data_bus : word_q;
    cmd_d = acc ? bus.i_cfg_start : beat ? cmd_q + stride_q : cmd_q;
    stride_d = acc ? bus.i_cfg_stride : stride_q;
    rem_d = acc ? beats(bus.i_cfg_count) : beat ? rem_q - 4'd1 : rem_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q <= '0;
      cmd_q <= '0;
      stride_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      cmd_q <= cmd_d;
      stride_q <= stride_d;
      rem_q <= rem_d;
    end
  end
  bit_selection_16x8_comb u_sel (
    .i_valid(run),
    .i_data(word_q),
    .i_cmd(cmd_q),
    .o_data(bus.o_data_bus)
  );
`ifdef BIT_SELECTION_SEQ_STATS_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;
  always_comb beat_cnt_d = (beat && beat_cnt_q != 16'hFFFF) ? beat_cnt_q + 16'd1 : beat_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) beat_cnt_q <= '0;
    else beat_cnt_q <= beat_cnt_d;
  end
  assign o_beat_cnt = beat_cnt_q;
`else
  assign o_beat_cnt = '0;
`endif
endmodule

// File: tb/tb_bit_selection_seq_ctrl.sv
// tb_bit_selection_seq_ctrl: directed checks of window beats, stall, back-to-back and reset behaviour
module tb_bit_selection_seq_ctrl;
  logic clk, rst;
  logic [15:0] beat_cnt;
  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  localparam logic [7:0] TAB [8] = '{8'hE1, 8'h70, 8'hB8, 8'h5C, 8'h2E, 8'h97, 8'h4B, 8'hA5};
`ifdef BIT_SELECTION_SEQ_STATS_EN
  localparam logic [15:0] EXP_BEATS = 16'd19;
`else
  localparam logic [15:0] EXP_BEATS = 16'd0;
`endif
  bit_selection_seq_ctrl_if #(.DATA_WIDTH(16), .COMMAND_WIDTH(3)) bus ();
  bit_selection_seq_ctrl #(.DATA_WIDTH(16), .COMMAND_WIDTH(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .o_beat_cnt(beat_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag, input logic rdy);
    #1;
    chk({tag, ".valid"}, bus.o_valid, 0);
    chk({tag, ".data"}, bus.o_data_bus, 0);
    chk({tag, ".cmd"}, bus.o_cmd, 0);
    chk({tag, ".last"}, bus.o_last, 0);
    chk({tag, ".ready"}, bus.o_ready, rdy);
  endtask
  task automatic beat(input string tag, input logic [7:0] d, input logic [2:0] c, input logic l);
    #1;
    chk({tag, ".valid"}, bus.o_valid, 1);
    chk({tag, ".data"}, bus.o_data_bus, d);
    chk({tag, ".cmd"}, bus.o_cmd, c);
    chk({tag, ".last"}, bus.o_last, l);
    tick();
  endtask
  task automatic accept(input logic [15:0] w, input logic [2:0] s, input logic [2:0] st, input logic [2:0] n);
    bus.i_valid = 1'b1;
    bus.i_data_bus = w;
    bus.i_cfg_start = s;
    bus.i_cfg_stride = st;
    bus.i_cfg_count = n;
    #1;
    chk("accept.ready", bus.o_ready, 1);
    tick();
    bus.i_valid = 1'b0;
    bus.i_data_bus = 16'hFFFF;
    bus.i_cfg_start = 3'd5;
    bus.i_cfg_stride = 3'd7;
    bus.i_cfg_count = 3'd5;
  endtask
  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data_bus = '0;
    bus.i_en = 1'b0;
    bus.i_cfg_start = '0;
    bus.i_cfg_stride = '0;
    bus.i_cfg_count = '0;
    bus.i_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_chk("reset", 0);
    chk("reset.beat_cnt", beat_cnt, 0);
    bus.i_en = 1'b1;
    accept(16'hA5C3, 3'd0, 3'd1, 3'd2);
    beat("w1b0", 8'hE1, 3'd0, 0);
    beat("w1b1", 8'h70, 3'd1, 1);
    idle_chk("w1.done", 1);
    accept(16'hA5C3, 3'd6, 3'd3, 3'd3);
    bus.i_en = 1'b0;
    beat("w2b0", 8'h4B, 3'd6, 0);
    beat("w2b1", 8'h70, 3'd1, 0);
    beat("w2b2", 8'h2E, 3'd4, 1);
    idle_chk("w2.done", 0);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    idle_chk("gated", 0);
    bus.i_en = 1'b1;
    accept(16'hA5C3, 3'd0, 3'd1, 3'd0);
    for (int k = 0; k < 8; k++) beat($sformatf("w3b%0d", k), TAB[k], 3'(k), k == 7);
    idle_chk("w3.done", 1);
    accept(16'hA5C3, 3'd0, 3'd1, 3'd3);
    beat("w4b0", 8'hE1, 3'd0, 0);
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall.valid", bus.o_valid, 1);
      chk("stall.data", bus.o_data_bus, 8'h70);
      chk("stall.cmd", bus.o_cmd, 1);
      chk("stall.last", bus.o_last, 0);
      chk("stall.ready", bus.o_ready, 0);
      tick();
    end
    bus.i_ready = 1'b1;
    beat("w4b1", 8'h70, 3'd1, 0);
    beat("w4b2", 8'hB8, 3'd2, 1);
    idle_chk("w4.done", 1);
    accept(16'hA5C3, 3'd0, 3'd1, 3'd1);
    bus.i_valid = 1'b1;
    bus.i_data_bus = 16'h1234;
    bus.i_cfg_start = 3'd2;
    bus.i_cfg_stride = 3'd1;
    bus.i_cfg_count = 3'd2;
    #1;
    chk("b2b.ready", bus.o_ready, 1);
    chk("b2b.last", bus.o_last, 1);
    chk("b2b.data", bus.o_data_bus, 8'hE1);
    chk("b2b.cmd", bus.o_cmd, 0);
    tick();
    bus.i_valid = 1'b0;
    beat("w6b0", 8'h46, 3'd2, 0);
    beat("w6b1", 8'h23, 3'd3, 1);
    idle_chk("w6.done", 1);
    chk("stats.beat_cnt", beat_cnt, EXP_BEATS);
    accept(16'hA5C3, 3'd0, 3'd1, 3'd4);
    beat("w7b0", 8'hE1, 3'd0, 0);
    rst = 1'b1;
    #1;
    chk("w7b1.data", bus.o_data_bus, 8'h70);
    tick();
    rst = 1'b0;
    idle_chk("rst_run", 1);
    chk("rst_run.beat_cnt", beat_cnt, 0);
    tick();
    idle_chk("rst_run.after", 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bit_selection_seq_ctrl.md
BIT_SELECTION_SEQ_CTRL -- requirements
Module: bit_selection_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, input word width (fixed at 16).
REQ-002 SHALL have parameter COMMAND_WIDTH, default 3, window-select command width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_valid, input, 1, upstream word valid.
REQ-006 SHALL have port i_data_bus, input, DATA_WIDTH, upstream 16-bit word.
REQ-007 SHALL have port o_ready, output, 1, ready to accept an upstream word.
REQ-008 SHALL have port i_en, input, 1, enables acceptance of new words.
REQ-009 SHALL have port i_cfg_start, input, COMMAND_WIDTH, first window command per word.
REQ-010 SHALL have port i_cfg_stride, input, COMMAND_WIDTH, command increment per beat.
REQ-011 SHALL have port i_cfg_count, input, 3, beats per word; 0 means 8.
REQ-012 SHALL have port o_valid, output, 1, output beat valid.
REQ-013 SHALL have port o_data_bus, output, DATA_WIDTH/2, selected 8-bit window.
REQ-014 SHALL have port i_ready, input, 1, downstream ready.
REQ-015 SHALL have port o_cmd, output, COMMAND_WIDTH, command of the current beat.
REQ-016 SHALL have port o_last, output, 1, current beat is the word's final beat.

Function
REQ-017 SHALL implement FSM states IDLE and RUN.
REQ-018 SHALL, in IDLE, drive o_ready = i_en; accept a word on i_valid && o_ready, latching data, start, stride and count, then enter RUN.
REQ-019 SHALL, in RUN, drive o_valid=1, o_cmd = current command, o_data_bus = word[cmd+1 +: 8].
REQ-020 SHALL, on a beat handshake (o_valid && i_ready), advance cmd = (cmd + stride) mod 8 and decrement the remaining count.
REQ-021 SHALL assert o_last when remaining count equals 1.
REQ-022 SHALL, on the last-beat handshake, drive o_ready = i_en; with a simultaneous upstream handshake, load the new word and stay in RUN (no bubble), otherwise go to IDLE.
REQ-023 SHALL hold o_data_bus, o_cmd and o_last stable while o_valid && !i_ready.
REQ-024 SHALL drive o_data_bus = 0, o_cmd = 0, o_last = 0 whenever o_valid = 0.
REQ-025 SHALL sample configuration only at word acceptance; changes during RUN have no effect on the in-flight word.
REQ-026 SHALL let an in-flight word complete when i_en deasserts; i_en gates acceptance only.
REQ-027 SHALL have latency 1: the first beat is valid in the cycle after acceptance.

Reset
REQ-028 SHALL, on rst, enter IDLE and clear cmd, count and the word register; o_valid=0, o_last=0, o_cmd=0, o_data_bus=0 in the cycle after rst is sampled.
REQ-029 SHALL drop any in-flight word on a reset asserted during RUN, with no further beats emitted.

Configuration
REQ-030 SHALL, with BIT_SELECTION_SEQ_STATS_EN defined, provide output o_beat_cnt (16 bits) counting beat handshakes, saturating at 0xFFFF, cleared by rst.
REQ-031 SHALL, without BIT_SELECTION_SEQ_STATS_EN, keep port o_beat_cnt tied to 0 with no counter logic.

Structure
REQ-032 SHALL place the FSM state encoding, COMMAND_WIDTH, and the count-zero-means-8 constant in package bit_selection_pkg.
REQ-033 SHALL instantiate bit_selection_16x8_comb as the window-select datapath, with its i_valid driven by the RUN state and its i_cmd by the command register.

Verification
REQ-034 SHALL cover: word 0xA5C3, start 0, stride 1, count 2, i_ready=1 -> beats 0xE1 (cmd 0), then 0x70 (cmd 1, o_last=1).
REQ-035 SHALL cover: start 6, stride 3, count 3 -> o_cmd sequence 6, 1, 4 (wrap), o_last on the third beat only.
REQ-036 SHALL cover: count 0 -> exactly 8 beats with stride 1, cmds 0..7.
REQ-037 SHALL cover: i_ready low for 3 cycles mid-word -> o_data_bus, o_cmd and o_last held; no beat lost or duplicated.
REQ-038 SHALL cover: second word presented at the last-beat handshake -> accepted in that cycle, first beat of the new word on the next cycle, no idle cycle.
REQ-039 SHALL cover: rst during beat 2 of 4 -> o_valid=0 next cycle, FSM in IDLE, o_ready = i_en.
